// File: rtl/flow_ctrl_pkg.sv
// Shared types and helpers for the flow-control datapath: FSM state encoding,
// byte-counter width, keep popcount and keep-trim mask.
package flow_ctrl_pkg;

    localparam int unsigned ByteCntW = 16;
    localparam int unsigned KeepMaxW = 64;

    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StFwd  = 2'd1;
    localparam state_t StDrop = 2'd2;

    function automatic logic [7:0] popcount(input logic [KeepMaxW-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < KeepMaxW; i++) begin
            n = n + 8'(v[i]);
        end
        return n;
    endfunction

    // Low-aligned mask of n ones; n >= KeepMaxW gives all ones.
    function automatic logic [KeepMaxW-1:0] keep_mask(input logic [7:0] n);
        logic [KeepMaxW:0] t;
        t = (65'd1 << n) - 65'd1;
        return t[KeepMaxW-1:0];
    endfunction

endpackage

// File: rtl/flow_skid_buf.sv
// Two-entry register slice with registered upstream ready; the head entry drives
// the output directly so output is fully registered.
module flow_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] head_q, tail_q;
    logic [1:0]       count_q, count_d;
    logic             ready_q;
    logic             push, pop;

    assign push = valid_i && ready_q;
    assign pop  = valid_o && ready_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
            if (pop) begin
                head_q <= (push && count_q == 2'd1) ? data_i : tail_q;
                if (push && count_q == 2'd2) begin
                    tail_q <= data_i;
                end
            end else if (push) begin
                if (count_q == 2'd0) begin
                    head_q <= data_i;
                end else begin
                    tail_q <= data_i;
                end
            end
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;

endmodule

// File: rtl/flow_frame_guard.sv
// Frame-length guard: truncates over-length frames, counts runts, registered output.
// Statistics counters are built only when FLOW_FRAME_GUARD_STAT_EN is defined.
module flow_frame_guard
    import flow_ctrl_pkg::*;
#(
    parameter int unsigned PORT_MNG_DATA_WIDTH = 128,
    parameter int unsigned REG_DATA_WIDTH      = 32,
    parameter int unsigned MIN_FRAME_BYTES     = 64
) (
    input  logic                             i_sys_clk,
    input  logic                             i_sys_rst,
    input  logic [REG_DATA_WIDTH-1:0]        i_max_frame_len,
    input  logic [PORT_MNG_DATA_WIDTH-1:0]   i_flow_data,
    input  logic [PORT_MNG_DATA_WIDTH/8-1:0] i_flow_data_keep,
    input  logic                             i_flow_valid,
    input  logic                             i_flow_last,
    output logic                             o_flow_ready,
    output logic [PORT_MNG_DATA_WIDTH-1:0]   o_flow_data,
    output logic [PORT_MNG_DATA_WIDTH/8-1:0] o_flow_data_keep,
    output logic                             o_flow_valid,
    output logic                             o_flow_last,
    input  logic                             i_flow_ready,
    output logic                             o_trunc_pulse,
    output logic [31:0]                      o_frame_cnt,
    output logic [31:0]                      o_trunc_cnt,
    output logic [31:0]                      o_runt_cnt
);

    localparam int unsigned KeepW = PORT_MNG_DATA_WIDTH / 8;
    localparam int unsigned SkidW = PORT_MNG_DATA_WIDTH + KeepW + 1;

    typedef logic [ByteCntW:0] sum_t;

    state_t              state_q, state_d;
    logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [ByteCntW-1:0] limit_q, limit;
    logic                trunc_pulse_q;
    logic                accept, fwd_state, over, push, skid_ready;
    logic                out_last, frame_done, is_runt;
    logic [KeepW-1:0]    trim_keep, out_keep;
    logic [7:0]          beat_pop;
    sum_t                beat_bytes, sum, kept_bytes;
    logic [SkidW-1:0]    skid_out;
    logic                unused_max_hi;

    assign unused_max_hi = ^i_max_frame_len[REG_DATA_WIDTH-1:ByteCntW];

    assign beat_pop   = popcount(KeepMaxW'(i_flow_data_keep));
    assign beat_bytes = sum_t'(beat_pop);
    assign fwd_state  = (state_q != StDrop);
    // Limit is taken live on the first beat and latched for the rest of the frame.
    assign limit      = (state_q == StIdle) ? i_max_frame_len[ByteCntW-1:0] : limit_q;
    assign sum        = sum_t'(byte_cnt_q) + beat_bytes;
    assign over       = (limit != '0) && (sum > sum_t'(limit));
    assign trim_keep  = KeepW'(keep_mask(8'(limit - byte_cnt_q)));
    assign out_keep   = over ? (i_flow_data_keep & trim_keep) : i_flow_data_keep;
    assign out_last   = i_flow_last || over;

    assign o_flow_ready = (state_q == StDrop) ? 1'b1 : skid_ready;
    assign accept       = i_flow_valid && o_flow_ready;
    assign push         = accept && fwd_state;
    assign frame_done   = push && out_last;
    assign kept_bytes   = over ? sum_t'(limit) : sum;
    assign is_runt      = kept_bytes < sum_t'(MIN_FRAME_BYTES);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        if (accept) begin
            if (fwd_state) begin
                if (i_flow_last) begin
                    state_d = StIdle;
                end else begin
                    state_d = over ? StDrop : StFwd;
                end
                byte_cnt_d = sum[ByteCntW] ? '1 : sum[ByteCntW-1:0];
            end else if (i_flow_last) begin
                state_d = StIdle;
            end
        end
        if (state_d == StIdle) begin
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q       <= StIdle;
            byte_cnt_q    <= '0;
            limit_q       <= '0;
            trunc_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            trunc_pulse_q <= push && over;
            if (accept && state_q == StIdle) begin
                limit_q <= i_max_frame_len[ByteCntW-1:0];
            end
        end
    end

    assign o_trunc_pulse = trunc_pulse_q;

    flow_skid_buf #(
        .Width (SkidW)
    ) u_skid (
        .clk_i   (i_sys_clk),
        .rst_ni  (i_sys_rst),
        .valid_i (push),
        .ready_o (skid_ready),
        .data_i  ({i_flow_data, out_keep, out_last}),
        .valid_o (o_flow_valid),
        .ready_i (i_flow_ready),
        .data_o  (skid_out)
    );

    assign {o_flow_data, o_flow_data_keep, o_flow_last} = skid_out;

`ifdef FLOW_FRAME_GUARD_STAT_EN
    logic [31:0] frame_cnt_q, trunc_cnt_q, runt_cnt_q;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
            runt_cnt_q  <= '0;
        end else begin
            if (frame_done && frame_cnt_q != '1) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (push && over && trunc_cnt_q != '1) begin
                trunc_cnt_q <= trunc_cnt_q + 32'd1;
            end
            if (frame_done && is_runt && runt_cnt_q != '1) begin
                runt_cnt_q <= runt_cnt_q + 32'd1;
            end
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_trunc_cnt = trunc_cnt_q;
    assign o_runt_cnt  = runt_cnt_q;
`else
    logic unused_stat;
    assign unused_stat = frame_done ^ is_runt;
    assign o_frame_cnt = '0;
    assign o_trunc_cnt = '0;
    assign o_runt_cnt  = '0;
`endif

endmodule

// File: tb/tb_flow_frame_guard.sv
// Self-checking bench for flow_frame_guard; counter expectations follow
// FLOW_FRAME_GUARD_STAT_EN when it is defined for the build.
module tb_flow_frame_guard;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

`ifdef FLOW_FRAME_GUARD_STAT_EN
    localparam bit Stat = 1'b1;
`else
    localparam bit Stat = 1'b0;
`endif

    logic         i_sys_clk = 1'b0;
    logic         i_sys_rst = 1'b0;
    logic [31:0]  i_max_frame_len = '0;
    logic [127:0] i_flow_data = '0;
    logic [15:0]  i_flow_data_keep = '0;
    logic         i_flow_valid = 1'b0;
    logic         i_flow_last = 1'b0;
    logic         o_flow_ready;
    logic [127:0] o_flow_data;
    logic [15:0]  o_flow_data_keep;
    logic         o_flow_valid;
    logic         o_flow_last;
    logic         i_flow_ready = 1'b1;
    logic         o_trunc_pulse;
    logic [31:0]  o_frame_cnt, o_trunc_cnt, o_runt_cnt;

    flow_frame_guard dut (
        .i_sys_clk        (i_sys_clk),
        .i_sys_rst        (i_sys_rst),
        .i_max_frame_len  (i_max_frame_len),
        .i_flow_data      (i_flow_data),
        .i_flow_data_keep (i_flow_data_keep),
        .i_flow_valid     (i_flow_valid),
        .i_flow_last      (i_flow_last),
        .o_flow_ready     (o_flow_ready),
        .o_flow_data      (o_flow_data),
        .o_flow_data_keep (o_flow_data_keep),
        .o_flow_valid     (o_flow_valid),
        .o_flow_last      (o_flow_last),
        .i_flow_ready     (i_flow_ready),
        .o_trunc_pulse    (o_trunc_pulse),
        .o_frame_cnt      (o_frame_cnt),
        .o_trunc_cnt      (o_trunc_cnt),
        .o_runt_cnt       (o_runt_cnt)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int           n_pass = 0, n_checks = 0;
    beat_t        exp_q[$], got_q[$];
    int           fb[$];
    logic [127:0] fd[$];
    int           exp_frames = 0, exp_trunc = 0, exp_runt = 0;
    int           pulse_cnt = 0, stable_err = 0;
    int           ready_mode = 0;  // 0: ready high, 1: held low, 2: random
    bit           prev_stall = 1'b0;
    beat_t        prev_beat;

    // Downstream sink: drives ready, records handshakes, tracks hold-stability.
    always @(negedge i_sys_clk) begin
        if (!i_sys_rst) begin
            prev_stall = 1'b0;
        end else begin
            case (ready_mode)
                0:       i_flow_ready = 1'b1;
                1:       i_flow_ready = 1'b0;
                default: i_flow_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (prev_stall && (!o_flow_valid ||
                               {o_flow_data, o_flow_data_keep, o_flow_last} !== prev_beat)) begin
                stable_err++;
            end
            if (o_trunc_pulse) pulse_cnt++;
            if (o_flow_valid && i_flow_ready) begin
                got_q.push_back({o_flow_data, o_flow_data_keep, o_flow_last});
            end
            prev_stall = o_flow_valid && !i_flow_ready;
            prev_beat  = {o_flow_data, o_flow_data_keep, o_flow_last};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] keep_of(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    function automatic logic [127:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void make_frame(input int nbytes);
        int left = nbytes;
        fb.delete();
        fd.delete();
        while (left > 16) begin
            fb.push_back(16);
            fd.push_back(rand_data());
            left -= 16;
        end
        fb.push_back(left);
        fd.push_back(rand_data());
    endfunction

    // Reference: keep whole beats while the running total stays within the limit; the
    // first beat that would exceed it is cut to the remaining bytes and closes the frame.
    function automatic void model_frame(input int limit);
        beat_t b;
        int    total = 0;
        for (int i = 0; i < fb.size(); i++) begin
            b.data = fd[i];
            if (limit != 0 && total + fb[i] > limit) begin
                b.keep = keep_of(limit - total);
                b.last = 1'b1;
                total  = limit;
                exp_trunc++;
            end else begin
                b.keep = keep_of(fb[i]);
                b.last = (i == fb.size() - 1);
                total += fb[i];
            end
            exp_q.push_back(b);
            if (b.last) begin
                exp_frames++;
                if (total < 64) exp_runt++;
                break;
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        int n = 0;
        i_flow_data      = d;
        i_flow_data_keep = k;
        i_flow_last      = l;
        i_flow_valid     = 1'b1;
        while (!o_flow_ready && n < 300) begin
            @(negedge i_sys_clk);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL send_timeout: o_flow_ready stayed 0, required 1 within 300 cycles");
        end
        @(negedge i_sys_clk);
        i_flow_valid = 1'b0;
    endtask

    task automatic drive_frame(input int limit, input int gap_max, input bit scramble);
        i_max_frame_len = {16'($urandom), 16'(limit)};
        for (int i = 0; i < fb.size(); i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge i_sys_clk);
            send_beat(fd[i], keep_of(fb[i]), i == fb.size() - 1);
            if (scramble) i_max_frame_len = $urandom;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin
            @(negedge i_sys_clk);
            n++;
        end
        repeat (8) @(negedge i_sys_clk);
    endtask

    task automatic test_reset();
        i_sys_rst = 1'b0;
        #2;
        n_checks++;
        if (o_flow_ready !== 1'b0 || o_flow_valid !== 1'b0 || o_flow_last !== 1'b0)
            $display("FAIL reset_ctrl: ready/valid/last=%b%b%b required 000",
                     o_flow_ready, o_flow_valid, o_flow_last);
        else n_pass++;
        n_checks++;
        if (o_flow_data !== '0 || o_flow_data_keep !== '0 || o_trunc_pulse !== 1'b0)
            $display("FAIL reset_data: data=%h keep=%h pulse=%b required zeros",
                     o_flow_data, o_flow_data_keep, o_trunc_pulse);
        else n_pass++;
        n_checks++;
        if ({o_frame_cnt, o_trunc_cnt, o_runt_cnt} !== 96'd0)
            $display("FAIL reset_cnt: %0d/%0d/%0d required 0/0/0",
                     o_frame_cnt, o_trunc_cnt, o_runt_cnt);
        else n_pass++;
        repeat (3) @(negedge i_sys_clk);
        n_checks++;
        if (o_flow_ready !== 1'b0)
            $display("FAIL reset_ready_clocked: got %b required 0", o_flow_ready);
        else n_pass++;
        i_sys_rst = 1'b1;
        @(negedge i_sys_clk);
        n_checks++;
        if (o_flow_ready !== 1'b1)
            $display("FAIL release_ready: got %b required 1", o_flow_ready);
        else n_pass++;
    endtask

    task automatic test_passthrough();
        beat_t g, e;
        ready_mode = 0;
        make_frame(100);
        model_frame(0);
        i_max_frame_len = '0;
        n_checks++;
        if (o_flow_valid !== 1'b0) $display("FAIL pass_idle_valid: got %b required 0", o_flow_valid);
        else n_pass++;
        send_beat(fd[0], keep_of(fb[0]), 1'b0);
        n_checks++;
        if (o_flow_valid !== 1'b1 || o_flow_data !== fd[0])
            $display("FAIL pass_latency: valid=%b data=%h required 1 and %h",
                     o_flow_valid, o_flow_data, fd[0]);
        else n_pass++;
        for (int i = 1; i < fb.size(); i++) send_beat(fd[i], keep_of(fb[i]), i == fb.size() - 1);
        wait_drain();
        n_checks++;
        if (got_q.size() != exp_q.size() || exp_q[exp_q.size()-1].keep !== 16'h000F)
            $display("FAIL pass_len: got %0d beats required %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL pass_beat: got %h/%h/%b required %h/%h/%b",
                                  g.data, g.keep, g.last, e.data, e.keep, e.last);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
        n_checks++;
        if ({o_frame_cnt, o_trunc_cnt, o_runt_cnt} !==
            (Stat ? {32'(exp_frames), 32'(exp_trunc), 32'(exp_runt)} : 96'd0))
            $display("FAIL pass_cnt: %0d/%0d/%0d required %0d/%0d/%0d", o_frame_cnt,
                     o_trunc_cnt, o_runt_cnt, exp_frames, exp_trunc, exp_runt);
        else n_pass++;
    endtask

    task automatic test_truncate();
        beat_t g, e;
        int    p0 = pulse_cnt;
        int    nbytes = 0;
        ready_mode = 0;
        make_frame(64);
        model_frame(40);
        i_max_frame_len = 32'd40;
        for (int i = 0; i < fb.size(); i++) begin
            send_beat(fd[i], keep_of(fb[i]), i == fb.size() - 1);
            if (i == 0) i_max_frame_len = 32'd200;
            if (i == 2) begin
                n_checks++;
                if (o_trunc_pulse !== 1'b1)
                    $display("FAIL trunc_pulse_timing: got %b required 1", o_trunc_pulse);
                else n_pass++;
            end
        end
        wait_drain();
        n_checks++;
        if (got_q.size() != 3) $display("FAIL trunc_len: got %0d beats required 3", got_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            nbytes += $countones(g.keep);
            n_checks++;
            if (g !== e) $display("FAIL trunc_beat: got %h/%h/%b required %h/%h/%b",
                                  g.data, g.keep, g.last, e.data, e.keep, e.last);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
        n_checks++;
        if (nbytes != 40 || pulse_cnt - p0 != 1)
            $display("FAIL trunc_total: bytes=%0d pulses=%0d required 40 and 1",
                     nbytes, pulse_cnt - p0);
        else n_pass++;
        n_checks++;
        if ({o_frame_cnt, o_trunc_cnt, o_runt_cnt} !==
            (Stat ? {32'(exp_frames), 32'(exp_trunc), 32'(exp_runt)} : 96'd0))
            $display("FAIL trunc_cnt: %0d/%0d/%0d required %0d/%0d/%0d", o_frame_cnt,
                     o_trunc_cnt, o_runt_cnt, exp_frames, exp_trunc, exp_runt);
        else n_pass++;
    endtask

    task automatic test_exact_and_runt();
        beat_t g, e;
        int    p0 = pulse_cnt;
        ready_mode = 0;
        make_frame(48);
        model_frame(48);
        drive_frame(48, 0, 1'b0);
        // Single 10-byte beat; the model counts it as a runt.
        make_frame(10);
        model_frame(0);
        drive_frame(0, 0, 1'b0);
        wait_drain();
        n_checks++;
        if (got_q.size() != 4 || pulse_cnt != p0)
            $display("FAIL exact_len: beats=%0d pulses=%0d required 4 and 0",
                     got_q.size(), pulse_cnt - p0);
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL exact_beat: got %h/%h/%b required %h/%h/%b",
                                  g.data, g.keep, g.last, e.data, e.keep, e.last);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
        n_checks++;
        if ({o_frame_cnt, o_trunc_cnt, o_runt_cnt} !==
            (Stat ? {32'(exp_frames), 32'(exp_trunc), 32'(exp_runt)} : 96'd0))
            $display("FAIL runt_cnt: %0d/%0d/%0d required %0d/%0d/%0d", o_frame_cnt,
                     o_trunc_cnt, o_runt_cnt, exp_frames, exp_trunc, exp_runt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        beat_t g, e;
        ready_mode = 1;
        stable_err = 0;
        @(negedge i_sys_clk);
        make_frame(96);
        model_frame(0);
        i_max_frame_len = '0;
        send_beat(fd[0], keep_of(fb[0]), 1'b0);
        send_beat(fd[1], keep_of(fb[1]), 1'b0);
        n_checks++;
        if (o_flow_ready !== 1'b0 || o_flow_valid !== 1'b1 || o_flow_data !== fd[0])
            $display("FAIL bp_full: ready=%b valid=%b data=%h required 0, 1, %h",
                     o_flow_ready, o_flow_valid, o_flow_data, fd[0]);
        else n_pass++;
        repeat (3) @(negedge i_sys_clk);
        n_checks++;
        if (o_flow_ready !== 1'b0 || o_flow_data !== fd[0])
            $display("FAIL bp_hold: ready=%b data=%h required 0 and %h",
                     o_flow_ready, o_flow_data, fd[0]);
        else n_pass++;
        ready_mode = 0;
        for (int i = 2; i < fb.size(); i++) send_beat(fd[i], keep_of(fb[i]), i == fb.size() - 1);
        wait_drain();
        n_checks++;
        if (got_q.size() != exp_q.size() || stable_err != 0)
            $display("FAIL bp_len: beats=%0d required %0d, unstable holds=%0d required 0",
                     got_q.size(), exp_q.size(), stable_err);
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL bp_beat: got %h/%h/%b required %h/%h/%b",
                                  g.data, g.keep, g.last, e.data, e.keep, e.last);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_in_drop();
        beat_t g, e;
        ready_mode = 0;
        make_frame(64);
        i_max_frame_len = 32'd20;
        for (int i = 0; i < 3; i++) send_beat(fd[i], keep_of(fb[i]), 1'b0);
        i_sys_rst = 1'b0;
        #1;
        n_checks++;
        if (o_flow_ready !== 1'b0 || o_flow_valid !== 1'b0 || o_flow_last !== 1'b0 ||
            o_trunc_pulse !== 1'b0)
            $display("FAIL rst_drop_ctrl: ready/valid/last/pulse=%b%b%b%b required 0000",
                     o_flow_ready, o_flow_valid, o_flow_last, o_trunc_pulse);
        else n_pass++;
        n_checks++;
        if (o_flow_data !== '0 || o_flow_data_keep !== '0 ||
            {o_frame_cnt, o_trunc_cnt, o_runt_cnt} !== 96'd0)
            $display("FAIL rst_drop_data: data=%h keep=%h cnt=%0d/%0d/%0d required zeros",
                     o_flow_data, o_flow_data_keep, o_frame_cnt, o_trunc_cnt, o_runt_cnt);
        else n_pass++;
        got_q.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_trunc  = 0;
        exp_runt   = 0;
        @(negedge i_sys_clk);
        i_sys_rst = 1'b1;
        @(negedge i_sys_clk);
        make_frame(64);
        model_frame(0);
        drive_frame(0, 0, 1'b0);
        wait_drain();
        n_checks++;
        if (got_q.size() != 4) $display("FAIL rst_frame_len: got %0d beats required 4", got_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL rst_frame_beat: got %h/%h/%b required %h/%h/%b",
                                  g.data, g.keep, g.last, e.data, e.keep, e.last);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
        n_checks++;
        if ({o_frame_cnt, o_trunc_cnt, o_runt_cnt} !== (Stat ? {32'd1, 32'd0, 32'd0} : 96'd0))
            $display("FAIL rst_frame_cnt: %0d/%0d/%0d required 1/0/0 (or 0s without stats)",
                     o_frame_cnt, o_trunc_cnt, o_runt_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        beat_t g, e;
        int    p0 = pulse_cnt;
        int    t0 = exp_trunc;
        int    nb, limit;
        ready_mode = 2;
        stable_err = 0;
        for (int f = 0; f < 40; f++) begin
            fb.delete();
            fd.delete();
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                fb.push_back(i == nb - 1 ? $urandom_range(1, 16) : $urandom_range(0, 16));
                fd.push_back(rand_data());
            end
            limit = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 100);
            model_frame(limit);
            drive_frame(limit, 2, 1'b1);
        end
        wait_drain();
        n_checks++;
        if (got_q.size() != exp_q.size() || stable_err != 0)
            $display("FAIL rand_len: beats=%0d required %0d, unstable holds=%0d required 0",
                     got_q.size(), exp_q.size(), stable_err);
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL rand_beat: got %h/%h/%b required %h/%h/%b",
                                  g.data, g.keep, g.last, e.data, e.keep, e.last);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
        n_checks++;
        if (pulse_cnt - p0 != exp_trunc - t0)
            $display("FAIL rand_pulses: got %0d required %0d", pulse_cnt - p0, exp_trunc - t0);
        else n_pass++;
        n_checks++;
        if ({o_frame_cnt, o_trunc_cnt, o_runt_cnt} !==
            (Stat ? {32'(exp_frames), 32'(exp_trunc), 32'(exp_runt)} : 96'd0))
            $display("FAIL rand_cnt: %0d/%0d/%0d required %0d/%0d/%0d", o_frame_cnt,
                     o_trunc_cnt, o_runt_cnt, exp_frames, exp_trunc, exp_runt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_truncate();
        test_exact_and_runt();
        test_back_to_back();
        test_reset_in_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
